// File: rtl/tile_update_queue_pkg.sv
// Shared tile types: object codes, grid size, RGB565 palette
// and the {x,y,code} request bundle.
package tile_pkg;

    localparam int GRID_W = 16;
    localparam int GRID_H = 12;

    typedef enum logic [2:0] {
        OBJ_EMPTY  = 3'd0,
        OBJ_HEAD   = 3'd1,
        OBJ_BODY   = 3'd2,
        OBJ_APPLE  = 3'd3,
        OBJ_BORDER = 3'd4
    } obj_code_t;

    localparam logic [15:0] RGB_BG     = 16'h0000;
    localparam logic [15:0] RGB_HEAD   = 16'h07E0;
    localparam logic [15:0] RGB_BODY   = 16'h03E0;
    localparam logic [15:0] RGB_APPLE  = 16'hF800;
    localparam logic [15:0] RGB_BORDER = 16'hFFFF;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        obj_code_t  code;
    } tile_req_t;

    function automatic logic [15:0] obj_color(obj_code_t c);
        case (c)
            OBJ_HEAD:   return RGB_HEAD;
            OBJ_BODY:   return RGB_BODY;
            OBJ_APPLE:  return RGB_APPLE;
            OBJ_BORDER: return RGB_BORDER;
            default:    return RGB_BG;
        endcase
    endfunction

endpackage

// File: rtl/tile_update_queue_sync_fifo.sv
// Single-clock FIFO with registered read data; a write into a
// full FIFO is accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
                rdata  <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/tile_update_queue.sv
// Queues changed grid cells from the frame scan and presents them
// to the display writer as RGB565 tile-paint requests.
module tile_update_queue
    import tile_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     enable,
    input  logic                     diff,
    input  logic [3:0]               x,
    input  logic [3:0]               y,
    input  logic [2:0]               obj_code,
    output logic                     upd_valid,
    input  logic                     upd_ready,
    output logic [3:0]               upd_x,
    output logic [3:0]               upd_y,
    output logic [15:0]              upd_color,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [CNT_W-1:0]         drop_cnt
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t    state;
    state_t    state_n;
    tile_req_t wr_req;
    tile_req_t head;
    logic      capture;
    logic      pop;
    logic      full;
    logic      empty;
    logic      drop;

    assign capture = enable & diff
                   & (obj_code <= 3'(OBJ_BORDER))
                   & (y <= 4'(GRID_H - 1));

    assign wr_req = '{x: x, y: y, code: obj_code_t'(obj_code)};

    assign pop  = ~empty & ((state == IDLE) | upd_ready);
    assign drop = capture & full & ~pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(tile_req_t))
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (capture),
        .pop   (pop),
        .wdata (wr_req),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (!empty) state_n = PRESENT;
            end
            PRESENT: begin
                if (upd_ready && empty) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request fields come straight from the FIFO's popped-entry register.
    assign upd_valid = (state == PRESENT);
    assign upd_x     = head.x;
    assign upd_y     = head.y;
    assign upd_color = obj_color(head.code);

    // A drop in the same cycle as a clear leaves a fresh count of one.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= CNT_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_tile_update_queue.sv
// Randomised and directed bench for tile_update_queue against a
// queue-based behavioural model of the capture/paint stream.
module tb_tile_update_queue;

    localparam int DEPTH = 16;
    localparam int CNT_W = 8;

    logic        tb_clk = 1'b0;
    logic        nrst;
    logic        enable;
    logic        diff;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [2:0]  obj_code;
    logic        upd_valid;
    logic        upd_ready;
    logic [3:0]  upd_x;
    logic [3:0]  upd_y;
    logic [15:0] upd_color;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        ovf_clr;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 tb_clk = ~tb_clk;

    tile_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (tb_clk),
        .nrst       (nrst),
        .enable     (enable),
        .diff       (diff),
        .x          (x),
        .y          (y),
        .obj_code   (obj_code),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_x      (upd_x),
        .upd_y      (upd_y),
        .upd_color  (upd_color),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .drop_cnt   (drop_cnt)
    );

    typedef struct {
        logic [3:0]  x;
        logic [3:0]  y;
        logic [15:0] color;
    } req_t;

    function automatic logic [15:0] ref_color(int c);
        case (c)
            0:       return 16'h0000;
            1:       return 16'h07E0;
            2:       return 16'h03E0;
            3:       return 16'hF800;
            default: return 16'hFFFF;
        endcase
    endfunction

    // Reference model: a queue of pending cells plus the one on offer.
    req_t mq[$];
    req_t m_cur;
    bit   m_valid;
    bit   m_ovf;
    int   m_drop;
    bit   m_take;
    bit   m_lost;

    always @(posedge tb_clk or negedge nrst) begin
        if (!nrst) begin
            mq.delete();
            m_valid = 0;
            m_ovf   = 0;
            m_drop  = 0;
        end else begin
            m_take = enable && diff && obj_code <= 3'd4 && y <= 4'd11;
            m_lost = 0;
            if (m_valid && upd_ready) m_valid = 0;
            if (!m_valid && mq.size() > 0) begin
                m_cur   = mq.pop_front();
                m_valid = 1;
            end
            if (m_take) begin
                if (mq.size() < DEPTH)
                    mq.push_back('{x, y, ref_color(int'(obj_code))});
                else
                    m_lost = 1;
            end
            if (ovf_clr) begin
                m_ovf  = 0;
                m_drop = 0;
            end
            if (m_lost) begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
    end

    task automatic tick;
        @(posedge tb_clk);
        #1;
    endtask

    task automatic idle_inputs;
        enable    = 1'b1;
        diff      = 1'b0;
        x         = 4'd0;
        y         = 4'd0;
        obj_code  = 3'd0;
        ovf_clr   = 1'b0;
    endtask

    task automatic test_reset;
        nrst      = 1'b0;
        idle_inputs();
        diff      = 1'b1;
        x         = 4'd3;
        y         = 4'd2;
        obj_code  = 3'd1;
        upd_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got=%b want=0", upd_valid);
        end
        n_checks++;
        if ({upd_x, upd_y, upd_color} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_req got=%h want=0", {upd_x, upd_y, upd_color});
        end
        n_checks++;
        if (fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_count got=%0d want=0", fifo_count);
        end
        n_checks++;
        if ({overflow, drop_cnt} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_ovf got=%b/%0d want=0/0", overflow, drop_cnt);
        end
        diff = 1'b0;
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_single;
        upd_ready = 1'b1;
        diff      = 1'b1;
        x         = 4'd4;
        y         = 4'd4;
        obj_code  = 3'd1;
        tick();
        diff = 1'b0;
        n_checks++;
        if (upd_valid !== 1'b0 || fifo_count !== 5'd1) begin
            n_fail++;
            $display("FAIL single_e0 got=%b/%0d want=0/1", upd_valid, fifo_count);
        end
        tick();
        n_checks++;
        if ({upd_valid, upd_x, upd_y, upd_color} !== {1'b1, 4'd4, 4'd4, 16'h07E0}) begin
            n_fail++;
            $display("FAIL single_req got=%b %0d %0d %h want=1 4 4 07e0",
                     upd_valid, upd_x, upd_y, upd_color);
        end
        tick();
        n_checks++;
        if (upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end got=%b want=0", upd_valid);
        end
    endtask

    task automatic test_backpressure;
        upd_ready = 1'b0;
        diff      = 1'b1;
        x         = 4'd5;
        y         = 4'd4;
        obj_code  = 3'd2;
        tick();
        x        = 4'd6;
        obj_code = 3'd3;
        tick();
        diff = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({upd_valid, upd_x, upd_y, upd_color, fifo_count}
                !== {1'b1, 4'd5, 4'd4, 16'h03E0, 5'd1}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got=%b %0d %0d %h cnt=%0d want=1 5 4 03e0 cnt=1",
                         i, upd_valid, upd_x, upd_y, upd_color, fifo_count);
            end
            if (i < 4) tick();
        end
        upd_ready = 1'b1;
        tick();
        n_checks++;
        if ({upd_valid, upd_x, upd_y, upd_color, fifo_count}
            !== {1'b1, 4'd6, 4'd4, 16'hF800, 5'd0}) begin
            n_fail++;
            $display("FAIL stall_next got=%b %0d %0d %h cnt=%0d want=1 6 4 f800 cnt=0",
                     upd_valid, upd_x, upd_y, upd_color, fifo_count);
        end
        tick();
        n_checks++;
        if (upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end got=%b want=0", upd_valid);
        end
    endtask

    task automatic drain(input int cycles, input string tag);
        upd_ready = 1'b1;
        diff      = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            n_checks++;
            if (upd_valid !== m_valid || fifo_count !== 5'(mq.size())
                || (m_valid && {upd_x, upd_y, upd_color} !== {m_cur.x, m_cur.y, m_cur.color})) begin
                n_fail++;
                $display("FAIL %s[%0d] got=%b %0d %0d %h cnt=%0d want=%b %0d %0d %h cnt=%0d",
                         tag, i, upd_valid, upd_x, upd_y, upd_color, fifo_count,
                         m_valid, m_cur.x, m_cur.y, m_cur.color, mq.size());
            end
        end
    endtask

    task automatic test_overflow;
        upd_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1 + 3; i++) begin
            diff     = 1'b1;
            x        = 4'($urandom);
            y        = 4'($urandom_range(11));
            obj_code = 3'($urandom_range(4));
            tick();
        end
        diff = 1'b0;
        n_checks++;
        if ({fifo_count, overflow, drop_cnt} !== {5'd16, 1'b1, 8'd3}) begin
            n_fail++;
            $display("FAIL ovf_state got cnt=%0d ovf=%b drop=%0d want 16 1 3",
                     fifo_count, overflow, drop_cnt);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_checks++;
        if ({fifo_count, overflow, drop_cnt, upd_valid} !== {5'd16, 1'b0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_clear got cnt=%0d ovf=%b drop=%0d vld=%b want 16 0 0 1",
                     fifo_count, overflow, drop_cnt, upd_valid);
        end
        drain(DEPTH + 3, "ovf_drain");
    endtask

    task automatic test_saturate;
        upd_ready = 1'b0;
        diff      = 1'b1;
        x         = 4'd9;
        y         = 4'd9;
        obj_code  = 3'd4;
        repeat (DEPTH + 1 + 260) tick();
        n_checks++;
        if ({overflow, drop_cnt} !== {1'b1, 8'hFF} || m_drop != 255) begin
            n_fail++;
            $display("FAIL drop_sat got=%b/%0d want=1/255", overflow, drop_cnt);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_checks++;
        if ({overflow, drop_cnt} !== {1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL clr_vs_drop got=%b/%0d want=1/1", overflow, drop_cnt);
        end
        drain(DEPTH + 3, "sat_drain");
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic test_filter;
        upd_ready = 1'b1;
        diff      = 1'b1;
        enable    = 1'b1;
        x         = 4'd2;
        y         = 4'd3;
        obj_code  = 3'd5;
        tick();
        obj_code = 3'd7;
        tick();
        obj_code = 3'd2;
        enable   = 1'b0;
        tick();
        enable = 1'b1;
        y      = 4'd12;
        tick();
        diff = 1'b0;
        tick();
        n_checks++;
        if ({upd_valid, fifo_count, drop_cnt, overflow} !== 15'h0) begin
            n_fail++;
            $display("FAIL filter got vld=%b cnt=%0d drop=%0d ovf=%b want all 0",
                     upd_valid, fifo_count, drop_cnt, overflow);
        end
    endtask

    task automatic test_reset_mid;
        upd_ready = 1'b0;
        diff      = 1'b1;
        x         = 4'd7;
        y         = 4'd1;
        obj_code  = 3'd3;
        repeat (3) tick();
        diff = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        n_checks++;
        if ({upd_valid, fifo_count} !== 6'h0) begin
            n_fail++;
            $display("FAIL async_rst got vld=%b cnt=%0d want 0 0", upd_valid, fifo_count);
        end
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_full_frame;
        logic [2:0] map1 [12][16];
        logic [2:0] map2 [12][16];
        req_t exp_q[$];
        req_t got_q[$];
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 16; c++) begin
                map1[r][c] = (r == 0 || r == 11 || c == 0 || c == 15) ? 3'd4 : 3'd0;
                map2[r][c] = map1[r][c];
            end
        map1[6][10] = 3'd3;
        map2[6][10] = 3'd3;
        map2[4][4]  = 3'd1;
        map2[4][5]  = 3'd2;
        map2[4][6]  = 3'd2;
        map2[4][7]  = 3'd2;
        map2[4][8]  = 3'd3;
        upd_ready = 1'b1;
        enable    = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 12; r++)
                for (int c = 0; c < 16; c++) begin
                    x        = 4'(c);
                    y        = 4'(r);
                    obj_code = (f == 0) ? map1[r][c] : map2[r][c];
                    diff     = (f == 1) && (map1[r][c] != map2[r][c]);
                    if (diff) exp_q.push_back('{4'(c), 4'(r), ref_color(int'(map2[r][c]))});
                    tick();
                    if (upd_valid) got_q.push_back('{upd_x, upd_y, upd_color});
                end
        diff = 1'b0;
        repeat (6) begin
            tick();
            if (upd_valid) got_q.push_back('{upd_x, upd_y, upd_color});
        end
        n_checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() != 5) begin
            n_fail++;
            $display("FAIL frame_count got=%0d want=5", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if ({got_q[i].x, got_q[i].y, got_q[i].color}
                !== {exp_q[i].x, exp_q[i].y, exp_q[i].color}) begin
                n_fail++;
                $display("FAIL frame_req[%0d] got=%0d,%0d %h want=%0d,%0d %h", i,
                         got_q[i].x, got_q[i].y, got_q[i].color,
                         exp_q[i].x, exp_q[i].y, exp_q[i].color);
            end
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_ovf got=%b want=0", overflow);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            enable    = ($urandom_range(7) != 0);
            diff      = $urandom_range(1);
            x         = 4'($urandom);
            y         = 4'($urandom);
            obj_code  = 3'($urandom);
            ovf_clr   = ($urandom_range(39) == 0);
            upd_ready = ((i / 60) % 2 == 1) ? ($urandom_range(4) == 0)
                                             : ($urandom_range(2) != 0);
            tick();
            n_checks++;
            if ({upd_valid, fifo_count, overflow, drop_cnt}
                !== {m_valid, 5'(mq.size()), m_ovf, 8'(m_drop)}
                || (m_valid && {upd_x, upd_y, upd_color} !== {m_cur.x, m_cur.y, m_cur.color})) begin
                n_fail++;
                $display("FAIL random[%0d] got=%b %0d %0d %h c%0d o%b d%0d want=%b %0d %0d %h c%0d o%b d%0d",
                         i, upd_valid, upd_x, upd_y, upd_color, fifo_count, overflow, drop_cnt,
                         m_valid, m_cur.x, m_cur.y, m_cur.color, mq.size(), m_ovf, m_drop);
            end
        end
        idle_inputs();
        drain(DEPTH + 3, "rand_drain");
    endtask

    initial begin
        upd_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_saturate();
        test_filter();
        test_reset_mid();
        test_full_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
